// File: rtl/lc3_mem_pkg.sv
// rtl/lc3_mem_pkg.sv - shared constants for the LC3 memory responder
package lc3_mem_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_ACK     = 2'd2;
  localparam logic [1:0] ST_RECOVER = 2'd3;

  // Device register offsets from the start of the I/O page.
  localparam logic [15:0] KBSR_OFS = 16'h0000;
  localparam logic [15:0] KBDR_OFS = 16'h0002;
  localparam logic [15:0] DSR_OFS  = 16'h0004;
  localparam logic [15:0] DDR_OFS  = 16'h0006;
  localparam logic [15:0] MCR_OFS  = 16'h01FE;

  localparam logic [15:0] MCR_RESET = 16'h8000;

endpackage

// File: rtl/lc3_mem_io_regs.sv
// rtl/lc3_mem_io_regs.sv - keyboard, display and machine control registers
module lc3_mem_io_regs
  import lc3_mem_pkg::*;
#(
  parameter logic [15:0] IO_BASE = 16'hFE00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [7:0]  kbd_data,
  input  logic        kbd_valid,
  input  logic        disp_ready,
  output logic [15:0] rdata,
  output logic [7:0]  disp_data,
  output logic        disp_valid,
  output logic [15:0] mcr,
  output logic        kbd_irq
);

  logic        kbd_ready_q, kbd_ready_d;
  logic        kbd_ie_q, kbd_ie_d;
  logic [7:0]  kbdr_q, kbdr_d;
  logic        disp_valid_q, disp_valid_d;
  logic [7:0]  disp_data_q, disp_data_d;
  logic [15:0] mcr_q, mcr_d;

  logic [15:0] ofs;
  logic        in_page;
  logic        sel_kbsr, sel_kbdr, sel_dsr, sel_ddr, sel_mcr;

  assign in_page  = (addr >= IO_BASE);
  assign ofs      = addr - IO_BASE;
  assign sel_kbsr = in_page && (ofs == KBSR_OFS);
  assign sel_kbdr = in_page && (ofs == KBDR_OFS);
  assign sel_dsr  = in_page && (ofs == DSR_OFS);
  assign sel_ddr  = in_page && (ofs == DDR_OFS);
  assign sel_mcr  = in_page && (ofs == MCR_OFS);

  always_comb begin
    rdata = 16'h0000;
    if (sel_kbsr) rdata = {kbd_ready_q, kbd_ie_q, 14'd0};
    if (sel_kbdr) rdata = {8'h00, kbdr_q};
    if (sel_dsr)  rdata = {~disp_valid_q, 15'd0};
    if (sel_ddr)  rdata = {8'h00, disp_data_q};
    if (sel_mcr)  rdata = mcr_q;
  end

  always_comb begin
    kbd_ready_d  = kbd_ready_q;
    kbd_ie_d     = kbd_ie_q;
    kbdr_d       = kbdr_q;
    disp_valid_d = disp_valid_q;
    disp_data_d  = disp_data_q;
    mcr_d        = mcr_q;
    if (wr_en && sel_kbsr) kbd_ie_d = wdata[14];
    if (rd_en && sel_kbdr) kbd_ready_d = 1'b0;
    // A fresh keystroke beats a KBDR read retiring in the same cycle.
    if (kbd_valid) begin
      kbd_ready_d = 1'b1;
      kbdr_d      = kbd_data;
    end
    if (disp_valid_q && disp_ready) disp_valid_d = 1'b0;
    if (wr_en && sel_ddr && !disp_valid_q) begin
      disp_valid_d = 1'b1;
      disp_data_d  = wdata[7:0];
    end
    if (wr_en && sel_mcr) mcr_d = wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kbd_ready_q  <= 1'b0;
      kbd_ie_q     <= 1'b0;
      kbdr_q       <= 8'h00;
      disp_valid_q <= 1'b0;
      disp_data_q  <= 8'h00;
      mcr_q        <= MCR_RESET;
    end else begin
      kbd_ready_q  <= kbd_ready_d;
      kbd_ie_q     <= kbd_ie_d;
      kbdr_q       <= kbdr_d;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
      mcr_q        <= mcr_d;
    end
  end

  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign mcr        = mcr_q;
  assign kbd_irq    = kbd_ready_q & kbd_ie_q;

endmodule

// File: rtl/lc3_mem_responder.sv
// rtl/lc3_mem_responder.sv - LC3 memory responder: handshake FSM, wait states, program RAM
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 12,
  parameter int          WAIT_STATES = 2,
  parameter logic [15:0] IO_BASE     = 16'hFE00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] memory_addr,
  input  logic [15:0] memory_din,
  input  logic        memWE,
  input  logic        memEN,
  output logic [15:0] memory_dout,
  output logic        memRDY,
  input  logic [7:0]  kbd_data,
  input  logic        kbd_valid,
  output logic [7:0]  disp_data,
  output logic        disp_valid,
  input  logic        disp_ready,
  output logic [15:0] mcr,
  output logic        kbd_irq
);

  localparam int         DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] din_q, din_d;
  logic        we_q, we_d;
  logic        rdy_q, rdy_d;
  logic [15:0] dout_q, dout_d;

  logic [15:0] ram_q [DEPTH];

  logic [15:0] acc_addr;
  logic        acc_we;
  logic        ram_hit;
  logic        in_ack;
  logic        io_rd, io_wr;
  logic [15:0] ram_rdata, io_rdata, rd_data;

  // With zero wait states ACK is entered straight from IDLE, so the read
  // must be decoded from the live request rather than the latched one.
  assign acc_addr  = (state_q == ST_IDLE) ? memory_addr : addr_q;
  assign acc_we    = (state_q == ST_IDLE) ? memWE : we_q;
  assign ram_hit   = (32'(acc_addr) < 32'(DEPTH));
  assign in_ack    = (state_q == ST_ACK);
  assign io_rd     = in_ack && !we_q && !ram_hit;
  assign io_wr     = in_ack && we_q && !ram_hit;
  assign ram_rdata = ram_q[acc_addr[DEPTH_LOG2-1:0]];
  assign rd_data   = ram_hit ? ram_rdata : io_rdata;

  lc3_mem_io_regs #(
    .IO_BASE (IO_BASE)
  ) u_io_regs (
    .clk        (clk),
    .rst        (rst),
    .addr       (acc_addr),
    .wdata      (din_q),
    .rd_en      (io_rd),
    .wr_en      (io_wr),
    .kbd_data   (kbd_data),
    .kbd_valid  (kbd_valid),
    .disp_ready (disp_ready),
    .rdata      (io_rdata),
    .disp_data  (disp_data),
    .disp_valid (disp_valid),
    .mcr        (mcr),
    .kbd_irq    (kbd_irq)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    din_d   = din_q;
    we_d    = we_q;
    case (state_q)
      ST_IDLE: begin
        if (memEN) begin
          addr_d  = memory_addr;
          din_d   = memory_din;
          we_d    = memWE;
          cnt_d   = WS;
          state_d = (WS != 4'd0) ? ST_WAIT : ST_ACK;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_ACK;
      end
      ST_ACK:     state_d = ST_RECOVER;
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    rdy_d  = (state_d == ST_ACK);
    dout_d = dout_q;
    if (rdy_d && !acc_we) dout_d = rd_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'h0000;
      din_q   <= 16'h0000;
      we_q    <= 1'b0;
      rdy_q   <= 1'b0;
      dout_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      we_q    <= we_d;
      rdy_q   <= rdy_d;
      dout_q  <= dout_d;
    end
  end

  // Program RAM keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (in_ack && we_q && ram_hit) ram_q[addr_q[DEPTH_LOG2-1:0]] <= din_q;
  end

  assign memRDY      = rdy_q;
  assign memory_dout = dout_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// tb/tb_lc3_mem_responder.sv - self-checking bench for lc3_mem_responder
module tb_lc3_mem_responder;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] memory_addr = 16'h0000;
  logic [15:0] memory_din = 16'h0000;
  logic        memWE = 1'b0;
  logic        memEN = 1'b0;
  logic        memEN0 = 1'b0;
  logic [7:0]  kbd_data = 8'h00;
  logic        kbd_valid = 1'b0;
  logic        disp_ready = 1'b0;

  logic [15:0] memory_dout, mcr, dout0, mcr0;
  logic        memRDY, disp_valid, kbd_irq, rdy0, dv0, irq0;
  logic [7:0]  disp_data, dd0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  lc3_mem_responder #(.DEPTH_LOG2(12), .WAIT_STATES(WS), .IO_BASE(16'hFE00)) u_dut (
    .clk(clk), .rst(rst), .memory_addr(memory_addr), .memory_din(memory_din),
    .memWE(memWE), .memEN(memEN), .memory_dout(memory_dout), .memRDY(memRDY),
    .kbd_data(kbd_data), .kbd_valid(kbd_valid), .disp_data(disp_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .mcr(mcr), .kbd_irq(kbd_irq)
  );

  lc3_mem_responder #(.DEPTH_LOG2(12), .WAIT_STATES(0), .IO_BASE(16'hFE00)) u_dut0 (
    .clk(clk), .rst(rst), .memory_addr(memory_addr), .memory_din(memory_din),
    .memWE(memWE), .memEN(memEN0), .memory_dout(dout0), .memRDY(rdy0),
    .kbd_data(kbd_data), .kbd_valid(kbd_valid), .disp_data(dd0),
    .disp_valid(dv0), .disp_ready(disp_ready), .mcr(mcr0), .kbd_irq(irq0)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: every access completes WS edges after it is
  // accepted, side effects land one edge later, and the responder is free
  // again WS+3 edges after acceptance.
  logic [15:0] m_ram [0:4095];
  logic        m_ready, m_ie, m_dv;
  logic [7:0]  m_kbdr, m_dd;
  logic [15:0] m_mcr, m_dout, m_addr, m_din;
  logic        m_we;
  bit          m_pend;
  int          m_ack, m_next;

  function automatic logic [15:0] m_read(input logic [15:0] a);
    if (a < 16'h1000) return m_ram[a[11:0]];
    case (a)
      16'hFE00: return {m_ready, m_ie, 14'd0};
      16'hFE02: return {8'h00, m_kbdr};
      16'hFE04: return {~m_dv, 15'd0};
      16'hFE06: return {8'h00, m_dd};
      16'hFFFE: return m_mcr;
      default:  return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin : model_p
    bit old_dv;
    bit set_dv;
    cyc++;
    if (!rst) begin
      m_ready = 1'b0; m_ie = 1'b0; m_kbdr = 8'h00; m_dv = 1'b0; m_dd = 8'h00;
      m_mcr = 16'h8000; m_dout = 16'h0000; m_pend = 1'b0; m_next = 0;
    end else begin
      old_dv = m_dv;
      set_dv = 1'b0;
      if (m_pend && cyc == m_ack && !m_we) m_dout = m_read(m_addr);
      if (m_pend && cyc == m_ack + 1) begin
        m_pend = 1'b0;
        if (m_we) begin
          if (m_addr < 16'h1000) m_ram[m_addr[11:0]] = m_din;
          else if (m_addr == 16'hFE00) m_ie = m_din[14];
          else if (m_addr == 16'hFE06 && !old_dv) begin
            m_dd = m_din[7:0];
            set_dv = 1'b1;
          end
          else if (m_addr == 16'hFFFE) m_mcr = m_din;
        end else if (m_addr == 16'hFE02) begin
          m_ready = 1'b0;
        end
      end
      if (kbd_valid) begin
        m_ready = 1'b1;
        m_kbdr = kbd_data;
      end
      if (old_dv && disp_ready) m_dv = 1'b0;
      if (set_dv) m_dv = 1'b1;
      if (!m_pend && cyc >= m_next && memEN) begin
        m_pend = 1'b1;
        m_addr = memory_addr;
        m_din = memory_din;
        m_we = memWE;
        m_ack = cyc + WS;
        m_next = cyc + WS + 3;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("memRDY", {15'd0, memRDY}, {15'd0, (m_pend && cyc == m_ack)});
      chk("memory_dout", memory_dout, m_dout);
      chk("mcr", mcr, m_mcr);
      chk("disp_valid", {15'd0, disp_valid}, {15'd0, m_dv});
      chk("disp_data", {8'd0, disp_data}, {8'd0, m_dd});
      chk("kbd_irq", {15'd0, kbd_irq}, {15'd0, m_ready & m_ie});
    end
  end

  task automatic access(input logic [15:0] a, input logic [15:0] d, input logic we,
                        input bit drop, output logic [15:0] q, output int lat);
    int c0;
    bit got;
    repeat (2) @(posedge clk);
    #1;
    memory_addr = a; memory_din = d; memWE = we; memEN = 1'b1;
    c0 = cyc; got = 1'b0; lat = -1; q = 16'hxxxx;
    if (drop) begin
      @(posedge clk);
      #1 memEN = 1'b0;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (memRDY) begin
        got = 1'b1;
        q = memory_dout;
        lat = cyc - c0;
      end
    end
    @(posedge clk);
    #1 memEN = 1'b0;
    memWE = 1'b0;
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL access_timeout addr %h: no memRDY within 40 cycles", a);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input bit drop = 1'b0);
    logic [15:0] q;
    int lat;
    access(a, d, 1'b1, drop, q, lat);
    chk("write_latency", 16'(lat), 16'(WS + 1));
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string nm);
    logic [15:0] q;
    int lat;
    access(a, 16'h0000, 1'b0, 1'b0, q, lat);
    chk(nm, q, exp);
    chk("read_latency", 16'(lat), 16'(WS + 1));
  endtask

  task automatic kbd_strobe(input logic [7:0] c);
    @(posedge clk);
    #1 kbd_data = c;
    kbd_valid = 1'b1;
    @(posedge clk);
    #1 kbd_valid = 1'b0;
  endtask

  task automatic wait0(output int t);
    bit got;
    got = 1'b0;
    t = -1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rdy0) begin
        got = 1'b1;
        t = cyc;
      end
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL ws0_timeout: no memRDY from zero-wait instance");
    end
  endtask

  initial begin
    int c0, t1, t2, t3, t4;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_memRDY", {15'd0, memRDY}, 16'd0);
    chk("rst_dout", memory_dout, 16'h0000);
    chk("rst_mcr", mcr, 16'h8000);
    chk("rst_disp_valid", {15'd0, disp_valid}, 16'd0);
    chk("rst_kbd_irq", {15'd0, kbd_irq}, 16'd0);
    chk("rst_ws0_outputs", {mcr0[15:8], dd0}, 16'h8000);
    chk("rst_ws0_flags", {14'd0, dv0, irq0}, 16'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // RAM write/read with wait states
    wr(16'h0010, 16'h1234);
    rd(16'h0010, 16'h1234, "ram_rd_0010");

    // keyboard
    kbd_strobe(8'h41);
    rd(16'hFE00, 16'h8000, "kbsr_ready");
    rd(16'hFE02, 16'h0041, "kbdr_char");
    rd(16'hFE00, 16'h0000, "kbsr_cleared");
    wr(16'hFE00, 16'h4000);
    rd(16'hFE00, 16'h4000, "kbsr_ie");
    kbd_strobe(8'h42);
    @(negedge clk);
    chk("kbd_irq_on", {15'd0, kbd_irq}, 16'd1);
    rd(16'hFE02, 16'h0042, "kbdr_char2");
    chk("kbd_irq_off", {15'd0, kbd_irq}, 16'd0);
    wr(16'hFE00, 16'h0000);

    // display
    disp_ready = 1'b0;
    wr(16'hFE06, 16'h0058);
    repeat (5) @(negedge clk);
    chk("disp_valid_held", {15'd0, disp_valid}, 16'd1);
    chk("disp_data_58", {8'd0, disp_data}, 16'h0058);
    rd(16'hFE04, 16'h0000, "dsr_busy");
    rd(16'hFE06, 16'h0058, "ddr_read");
    wr(16'hFE06, 16'h0059);
    chk("ddr_dropped", {8'd0, disp_data}, 16'h0058);
    @(posedge clk);
    #1 disp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("disp_valid_cleared", {15'd0, disp_valid}, 16'd0);
    disp_ready = 1'b0;
    rd(16'hFE04, 16'h8000, "dsr_ready");

    // MCR
    wr(16'hFFFE, 16'h0000);
    chk("mcr_zero", mcr, 16'h0000);
    rd(16'hFFFE, 16'h0000, "mcr_rd0");
    wr(16'hFFFE, 16'hABCD);
    rd(16'hFFFE, 16'hABCD, "mcr_rdback");

    // reset in the middle of a wait state
    @(posedge clk);
    #1 memory_addr = 16'h0010;
    memWE = 1'b0;
    memEN = 1'b1;
    @(posedge clk);
    #1 memEN = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_mid_wait_rdy", {15'd0, memRDY}, 16'd0);
    end
    chk("rst_mid_wait_mcr", mcr, 16'h8000);
    @(posedge clk);
    #1 rst = 1'b1;
    rd(16'h0010, 16'h1234, "ram_survives_rst");

    // unmapped and RAM boundary
    wr(16'h0000, 16'hBEEF);
    rd(16'hC000, 16'h0000, "unmapped_rd");
    wr(16'hC000, 16'h1111);
    rd(16'h0000, 16'hBEEF, "unmapped_wr_ignored");
    wr(16'h0FFF, 16'h0F0F);
    rd(16'h0FFF, 16'h0F0F, "ram_top");
    wr(16'h1000, 16'h2222);
    rd(16'h1000, 16'h0000, "above_ram_rd");
    rd(16'h0000, 16'hBEEF, "above_ram_no_alias");

    // core drops memEN after acceptance
    wr(16'h0020, 16'h7777, 1'b1);
    rd(16'h0020, 16'h7777, "dropped_en_write");

    // zero wait states, memEN held for back-to-back accesses
    @(posedge clk);
    #1 memory_addr = 16'h0000;
    memory_din = 16'hAAAA;
    memWE = 1'b1;
    memEN0 = 1'b1;
    c0 = cyc;
    wait0(t1);
    chk("ws0_first_latency", 16'(t1 - c0), 16'd1);
    memory_addr = 16'h0001;
    memory_din = 16'h5555;
    wait0(t2);
    chk("ws0_gap_1", 16'(t2 - t1), 16'd3);
    memWE = 1'b0;
    memory_addr = 16'h0000;
    wait0(t3);
    chk("ws0_gap_2", 16'(t3 - t2), 16'd3);
    chk("ws0_rd_0000", dout0, 16'hAAAA);
    memory_addr = 16'h0001;
    wait0(t4);
    chk("ws0_gap_3", 16'(t4 - t3), 16'd3);
    chk("ws0_rd_0001", dout0, 16'h5555);
    @(posedge clk);
    #1 memEN0 = 1'b0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lc3_mem_responder.md
Name: lc3_mem_responder

Overview:
Responder end of the LC3 core memory handshake. It accepts a request on memEN, address, write data and write enable, inserts programmable wait states, then returns read data with a one-cycle memRDY pulse. It contains the word-addressed program RAM and the standard LC3 device registers (KBSR/KBDR/DSR/DDR/MCR). It sits beside the core at top level; its mcr output feeds the core's MCR input and kbd_irq feeds IRQ.

Parameters:
DEPTH_LOG2, 12, RAM holds 2**DEPTH_LOG2 16-bit words at addresses 0..2**DEPTH_LOG2-1
WAIT_STATES, 2, extra cycles between request acceptance and memRDY (0..15)
IO_BASE, 16'hFE00, first address of the device page (FE00-FFFF)

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
memory_addr  in  16  request word address
memory_din  in  16  write data from core
memWE  in  1  1=write, 0=read; sampled with memEN
memEN  in  1  request valid; core holds addr/din/WE stable until memRDY
memory_dout  out  16  registered read data, valid in memRDY cycle
memRDY  out  1  one-cycle completion pulse
kbd_data  in  8  keyboard character
kbd_valid  in  1  one-cycle strobe: new character
disp_data  out  8  character to display
disp_valid  out  1  display character pending
disp_ready  in  1  display accepts character when disp_valid&disp_ready
mcr  out  16  machine control register
kbd_irq  out  1  KBSR[15] & KBSR[14]

Behaviour:
- Reset (rst=0, async): FSM=IDLE, memRDY=0, memory_dout=0, KBSR=0, KBDR=0, disp_valid=0, disp_data=0, mcr=16'h8000, kbd_irq=0. RAM contents not reset.
- FSM states IDLE, WAIT, ACK, RECOVER.
- IDLE: memEN=1 at edge T -> latch addr/din/WE, counter=WAIT_STATES; go WAIT if WAIT_STATES>0 else ACK.
- WAIT: decrement each cycle; at 1 go ACK. memEN ignored.
- ACK: memRDY=1 for exactly this cycle (cycle T+WAIT_STATES+1). Reads: memory_dout holds data, loaded on entry. Writes commit at the edge leaving ACK; memory_dout unchanged on writes. Next state RECOVER.
- RECOVER: one cycle, memRDY=0, memEN ignored; then IDLE. A still-asserted memEN in IDLE starts a new access.
- Core dropping memEN mid-access: access still completes (write still commits).
- Address decode on latched addr: addr<2**DEPTH_LOG2 -> RAM. FE00 KBSR, FE02 KBDR, FE04 DSR, FE06 DDR, FFFE MCR. All other addresses: read 0, write ignored.
- KBSR: bit15 ready, bit14 IE, others read 0. kbd_valid sets ready and loads KBDR[7:0]; overwrites an unread char. Core write updates only bit14. Read of KBDR (ACK cycle) clears ready; kbd_valid in same cycle wins (ready stays 1, new data).
- DSR: bit15 = ~disp_valid, others 0; writes ignored.
- DDR write: if disp_valid=0 load disp_data=din[7:0], disp_valid=1; if disp_valid=1 write dropped. disp_valid clears the cycle after disp_valid&disp_ready. DDR reads return {8'h0,disp_data}.
- MCR: read/write full 16 bits. mcr[15]=0 gates the core clock; block keeps running.

Decomposition:
- Package lc3_mem_pkg: state enum (IDLE/WAIT/ACK/RECOVER), device address constants (KBSR/KBDR/DSR/DDR/MCR), MCR reset value.
- Sub-module lc3_mem_io_regs: keyboard/display/MCR registers, decode by latched addr with rd/wr strobes from ACK. RAM array and FSM stay in top.

Test Plan:
- Reset then write 16'h1234 to 0x0010 (WAIT_STATES=2) -> memRDY only at cycle T+3. Read 0x0010 -> memory_dout=16'h1234 with memRDY.
- WAIT_STATES=0, memEN held high for back-to-back reads of 0x0000/0x0001 -> memRDY at T+1, RECOVER gap, next access accepted cycle T+3.
- kbd_valid with kbd_data=8'h41 -> KBSR read=16'h8000, KBDR read=16'h0041, next KBSR read=16'h0000. With KBSR written 16'h4000 -> kbd_irq=1 on strobe.
- Write DDR=16'h0058, disp_ready=0 for 5 cycles -> disp_valid=1, disp_data=8'h58, DSR=0. Second DDR write dropped. disp_ready=1 -> DSR=16'h8000 next cycle.
- Write MCR=16'h0000 -> mcr=0, read back 0. Assert rst mid-WAIT -> memRDY never pulses, mcr=16'h8000.
- Read 0xC000 (unmapped) -> memory_dout=0. Write to 0xC000 then read 0x0000 -> RAM unchanged.
